bcd_press_counter: RTL and testbench
====================================

// Module: bcd_press_counter
// PURPOSE
//  Upstream digit source for the 4-digit multiplexed seven-segment driver. Takes two raw
//  active-low push-buttons (increment, clear), synchronises and debounces them, and keeps
//  a 4-digit BCD count. Outputs digit1..digit4 as 4-bit BCD, always in 0..9, ready for the
//  display's seven_seg[] lookup.
//  digit1 = units, on the first display position.
// PARAMETERS
//  DEBOUNCE_CYCLES  270_000     stable-sample count before a button change is accepted (10 ms @ 27 MHz)
//  REPEAT_DELAY     13_500_000  hold time before auto-repeat starts (0.5 s @ 27 MHz); HOLD_REPEAT_EN only
//  REPEAT_PERIOD    2_700_000   cycles between auto-repeat increments (0.1 s); HOLD_REPEAT_EN only
// PORTS
//  clk        in   1  system clock, 27 MHz
//  rst_n      in   1  asynchronous active-low reset
//  btn_inc_n  in   1  raw increment button, low = pressed, asynchronous to clk
//  btn_clr_n  in   1  raw clear button, low = pressed, asynchronous to clk
//  digit1     out  4  BCD units
//  digit2     out  4  BCD tens
//  digit3     out  4  BCD hundreds
//  digit4     out  4  BCD thousands
//  inc_pulse  out  1  1-cycle strobe on every accepted increment
//  wrap       out  1  1-cycle strobe when the count rolls 9999 -> 0000
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - digits = 0; inc_pulse = 0; wrap = 0.
//    - Synchronisers and debounced states = released (1).
//    - Debounce counters = 0; repeat FSM = IDLE.
//  - Input path, per button:
//    - 2-FF synchroniser, reset value 1.
//    - Debounce counter clears whenever the synced value equals the debounced state.
//    - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still
//      differing, the debounced state flips on the next edge and the counter clears.
//    - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
//  - Press event = debounced state 1->0, detected on a registered copy.
//    - Release events are ignored.
//    - Latency, steady pin low -> digit change = DEBOUNCE_CYCLES+3 cycles.
//  - Increment: BCD ripple in one cycle.
//    - digit1 += 1; at 9 it goes to 0 and carries into digit2, and so on up the digits.
//    - 9999 -> 0000 asserts wrap in the same cycle the digits change.
//    - inc_pulse is registered alongside the digits.
//  - Clear press: all digits -> 0 on the next edge; no inc_pulse, no wrap.
//  - Simultaneous clear and increment in the same cycle: clear wins, increment dropped.
//  - A clear held low blocks increments for as long as it is held.
//  - Outputs change only on clk edges; digits never hold a value >9.
// CONFIGURATION
//  HOLD_REPEAT_EN defined:
//    - Increment FSM states: IDLE -> HELD on press (one increment issued).
//    - HELD -> REPEAT after REPEAT_DELAY cycles still pressed.
//    - REPEAT issues one increment every REPEAT_PERIOD cycles while pressed.
//    - Any debounced release or any clear press -> IDLE, with the timer zeroed.
//    - Repeat increments assert inc_pulse and wrap exactly like press increments.
//  HOLD_REPEAT_EN undefined:
//    - Exactly one increment per press; no repeat timer logic is synthesised.
//    - REPEAT_* parameters are unused.
// TESTING (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
//  1. Reset mid-count (digits=0042), pulse rst_n low asynchronously
//     -> digits=0000, inc_pulse=0, wrap=0 with no clk edge.
//  2. btn_inc_n low for 3 cycles then high -> no change.
//     Low for 10 cycles -> digits 0000->0001 at cycle 7 after the fall, single inc_pulse.
//  3. Preload 0099 via 99 presses, press once -> 0100.
//     Preload 9999, press -> 0000 with wrap=1 and inc_pulse=1 in the same cycle.
//  4. Both buttons fall on the same cycle with digits=0005 -> 0000, inc_pulse stays 0.
//  5. Bounce btn_inc_n 1/0 every cycle for 30 cycles, then steady low -> exactly one increment.
//  6. HOLD_REPEAT_EN: hold inc for 40 cycles after acceptance
//     -> increments at 0, 20, 25, 30, 35 (5 total).
//     Without the macro -> 1 increment.

Source files
------------

// File: rtl/bcd_press_counter.sv
// Two raw active-low buttons (increment, clear) are synchronised and debounced and drive a 4-digit BCD count.
// Define HOLD_REPEAT_EN to make a held increment button auto-repeat after a delay.
module bcd_press_counter #(
  parameter int DEBOUNCE_CYCLES = 270_000,
  parameter int REPEAT_DELAY    = 13_500_000,
  parameter int REPEAT_PERIOD   = 2_700_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_inc_n,
  input  logic       btn_clr_n,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic       inc_pulse,
  output logic       wrap
);

  localparam int DB_W = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is the increment button, bit 1 the clear button.
  logic [1:0]      raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      db;
  logic [1:0]      db_d;
  logic [DB_W-1:0] db_cnt [2];

  assign raw = {btn_clr_n, btn_inc_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
      db    <= 2'b11;
      db_d  <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_d  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic inc_press;
  logic clr_press;
  logic inc_go;

  assign inc_press = db_d[0] & ~db[0];
  assign clr_press = db_d[1] & ~db[1];

`ifdef HOLD_REPEAT_EN
  localparam int RT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RT_W   = ($clog2(RT_MAX) > 0) ? $clog2(RT_MAX) : 1;
  localparam logic [RT_W-1:0] DELAY_LAST  = RT_W'(REPEAT_DELAY - 1);
  localparam logic [RT_W-1:0] PERIOD_LAST = RT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} rpt_state_t;

  rpt_state_t      state;
  logic [RT_W-1:0] timer;
  logic            hold_ok;

  // A debounced release or a clear (pressed or still held) ends the hold.
  assign hold_ok = ~db[0] & db[1];

  always_comb begin
    inc_go = 1'b0;
    case (state)
      IDLE:    inc_go = inc_press & db[1];
      HELD:    inc_go = hold_ok & (timer == DELAY_LAST);
      REPEAT:  inc_go = hold_ok & (timer == PERIOD_LAST);
      default: inc_go = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (inc_press && db[1]) begin
            state <= HELD;
          end
        end
        HELD: begin
          if (!hold_ok) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == DELAY_LAST) begin
            state <= REPEAT;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        REPEAT: begin
          if (!hold_ok) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == PERIOD_LAST) begin
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end
`else
  // A held clear suppresses increments; a simultaneous clear press therefore wins.
  assign inc_go = inc_press & db[1];
`endif

  logic [3:0][3:0] digits;
  logic [3:0][3:0] next_digits;
  logic            ripple;

  always_comb begin
    next_digits = digits;
    ripple      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (ripple) begin
        if (digits[i] >= 4'd9) begin
          next_digits[i] = 4'd0;
        end else begin
          next_digits[i] = digits[i] + 4'd1;
          ripple         = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits    <= '0;
      inc_pulse <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      inc_pulse <= 1'b0;
      wrap      <= 1'b0;
      if (clr_press) begin
        digits <= '0;
      end else if (inc_go) begin
        digits    <= next_digits;
        inc_pulse <= 1'b1;
        wrap      <= ripple;
      end
    end
  end

  assign digit1 = digits[0];
  assign digit2 = digits[1];
  assign digit3 = digits[2];
  assign digit4 = digits[3];

endmodule

// File: tb/tb_bcd_press_counter.sv
// Bench for bcd_press_counter: a pin-history model checked every cycle plus literal expectations.
// Build with HOLD_REPEAT_EN defined to check the auto-repeat variant.
module tb_bcd_press_counter;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;
`ifdef HOLD_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_inc_n = 1'b1;
  logic       btn_clr_n = 1'b1;
  logic [3:0] digit1, digit2, digit3, digit4;
  logic       inc_pulse, wrap;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_press_counter #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_inc_n(btn_inc_n),
    .btn_clr_n(btn_clr_n),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .digit4   (digit4),
    .inc_pulse(inc_pulse),
    .wrap     (wrap)
  );

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  // Model: a button change is accepted once the last DB synchronised samples all disagree
  // with the accepted state; the count then moves on the following edge.
  int m_count = 0;
  bit m_inc = 0, m_wrap = 0;
  bit m_inc_db = 1, m_clr_db = 1;
  bit inc_ev = 0, clr_ev = 0;
  bit held = 0;
  int edge_n = 0, t0 = 0;
  bit inc_hist [DB+1];
  bit clr_hist [DB+1];

  always @(posedge clk or negedge rst_n) begin : model_step
    bit go, inc_all, clr_all;
    if (!rst_n) begin
      m_count = 0; m_inc = 0; m_wrap = 0;
      m_inc_db = 1; m_clr_db = 1; inc_ev = 0; clr_ev = 0; held = 0;
      for (int i = 0; i <= DB; i++) begin
        inc_hist[i] = 1'b1;
        clr_hist[i] = 1'b1;
      end
    end else begin
      edge_n++;
      m_inc = 0; m_wrap = 0; go = 0;
      if (clr_ev) begin
        m_count = 0;
        held = 0;
      end else if (inc_ev && m_clr_db) begin
        go = 1;
        held = REPEAT_ON;
        t0 = edge_n;
      end else if (held) begin
        if (m_inc_db || !m_clr_db) held = 0;
        else if (edge_n - t0 >= RD && (edge_n - t0 - RD) % RP == 0) go = 1;
      end
      if (go) begin
        m_inc = 1;
        m_wrap = (m_count == 9999);
        m_count = (m_count + 1) % 10000;
      end
      inc_all = 1; clr_all = 1;
      for (int i = 1; i <= DB; i++) begin
        if (inc_hist[i] == m_inc_db) inc_all = 0;
        if (clr_hist[i] == m_clr_db) clr_all = 0;
      end
      inc_ev = 0; clr_ev = 0;
      if (inc_all) begin m_inc_db = ~m_inc_db; inc_ev = !m_inc_db; end
      if (clr_all) begin m_clr_db = ~m_clr_db; clr_ev = !m_clr_db; end
      for (int i = DB; i >= 1; i--) begin
        inc_hist[i] = inc_hist[i-1];
        clr_hist[i] = clr_hist[i-1];
      end
      inc_hist[0] = btn_inc_n;
      clr_hist[0] = btn_clr_n;
    end
  end

  bit cmp_en = 0;
  int pulse_cnt = 0;
  int wrap_cnt = 0;

  always @(negedge clk) begin
    if (inc_pulse) pulse_cnt++;
    if (inc_pulse && wrap) wrap_cnt++;
    if (cmp_en) begin
      check("digits", {digit4, digit3, digit2, digit1}, to_bcd(m_count));
      check("inc_pulse", inc_pulse, m_inc);
      check("wrap", wrap, m_wrap);
      check("digit_range", int'(digit1 > 9 || digit2 > 9 || digit3 > 9 || digit4 > 9), 0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press_inc(input int low, input int high);
    btn_inc_n = 1'b0;
    cycles(low);
    btn_inc_n = 1'b1;
    cycles(high);
  endtask

  task automatic presses(input int n);
    for (int i = 0; i < n; i++) press_inc(DB, DB);
    cycles(4);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: bench still running at %0t, limit 1500000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, w0, lat;
    logic [3:0] d_prev;
    cycles(3);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    cycles(2);

    // Reset mid-count, asserted away from any clock edge
    presses(42);
    check("preload_42", {digit4, digit3, digit2, digit1}, 16'h0042);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_digits", {digit4, digit3, digit2, digit1}, 16'h0000);
    check("async_rst_pulse", inc_pulse, 0);
    check("async_rst_wrap", wrap, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);

    // Short glitch rejected; steady press accepted 7 edges after the fall
    p0 = pulse_cnt;
    press_inc(3, 10);
    check("glitch_digits", {digit4, digit3, digit2, digit1}, 16'h0000);
    check("glitch_pulses", pulse_cnt - p0, 0);
    p0 = pulse_cnt;
    lat = 0;
    d_prev = digit1;
    btn_inc_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (lat == 0 && digit1 != d_prev) lat = i;
      if (i == 10) btn_inc_n = 1'b1;
    end
    cycles(4);
    check("latency", lat, DB + 3);
    check("press_digits", {digit4, digit3, digit2, digit1}, 16'h0001);
    check("press_pulses", pulse_cnt - p0, 1);

    // Held clear clears and blocks increments
    p0 = pulse_cnt;
    btn_clr_n = 1'b0;
    cycles(8);
    press_inc(DB, DB);
    cycles(4);
    btn_clr_n = 1'b1;
    cycles(8);
    check("clr_hold_digits", {digit4, digit3, digit2, digit1}, 16'h0000);
    check("clr_hold_pulses", pulse_cnt - p0, 0);

    // BCD carries and the 9999 -> 0000 wrap
    presses(99);
    check("preload_99", {digit4, digit3, digit2, digit1}, 16'h0099);
    presses(1);
    check("carry_100", {digit4, digit3, digit2, digit1}, 16'h0100);
    presses(9899);
    check("preload_9999", {digit4, digit3, digit2, digit1}, 16'h9999);
    w0 = wrap_cnt;
    p0 = pulse_cnt;
    presses(1);
    check("wrap_digits", {digit4, digit3, digit2, digit1}, 16'h0000);
    check("wrap_with_pulse", wrap_cnt - w0, 1);
    check("wrap_pulses", pulse_cnt - p0, 1);

    // Clear and increment falling together: clear wins
    presses(5);
    check("preload_5", {digit4, digit3, digit2, digit1}, 16'h0005);
    p0 = pulse_cnt;
    btn_inc_n = 1'b0;
    btn_clr_n = 1'b0;
    cycles(6);
    btn_inc_n = 1'b1;
    btn_clr_n = 1'b1;
    cycles(10);
    check("both_digits", {digit4, digit3, digit2, digit1}, 16'h0000);
    check("both_pulses", pulse_cnt - p0, 0);

    // Bouncing contact then a steady press: one increment
    p0 = pulse_cnt;
    for (int i = 0; i < 30; i++) begin
      btn_inc_n = ~btn_inc_n;
      @(negedge clk);
    end
    press_inc(8, 8);
    cycles(4);
    check("bounce_digits", {digit4, digit3, digit2, digit1}, 16'h0001);
    check("bounce_pulses", pulse_cnt - p0, 1);

    // Long hold: released so the debounced release lands before acceptance + 40
    p0 = pulse_cnt;
    press_inc(38, 10);
    cycles(4);
    check("hold_pulses", pulse_cnt - p0, REPEAT_ON ? 5 : 1);
    check("hold_digits", {digit4, digit3, digit2, digit1}, REPEAT_ON ? 16'h0006 : 16'h0002);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
